clock_ref_out: RTL



---
 rtl/clock_ref_out_pkg.sv | 8 +
 rtl/clock_ref_out_pps.sv | 29 ++
 rtl/clock_ref_out.sv | 68 ++++++
 3 files changed

// File: rtl/clock_ref_out_pkg.sv
// clock_ref_out_pkg: shared state encoding, adjust directions and default dividers.
package clock_ref_out_pkg;
   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
   localparam logic ADJ_ADVANCE = 1'b1;
   localparam logic ADJ_RETARD = 1'b0;
   localparam int DEF_DIV = 25;
   localparam int DEF_PPS_DIV = 10000000;
endpackage

// File: rtl/clock_ref_out_pps.sv
// clock_ref_out_pps: period counter and one-cycle marker aligned with the first high half of period 0.
module clock_ref_out_pps
   import clock_ref_out_pkg::*;
#(
   parameter int PPS_DIV = DEF_PPS_DIV
) (
   input  logic clk_250mhz,
   input  logic rst_250mhz,
   input  logic wrap,
   input  logic idle,
   output logic pps_out
);
   localparam int PW = $clog2(PPS_DIV);
   localparam logic [PW-1:0] LAST = PW'(PPS_DIV - 1);
   logic [PW-1:0] per;
   logic start;
   // start flags the cycle whose cnt begins a new period, so retard/advance never double-count
   always_ff @(posedge clk_250mhz) begin
      if (rst_250mhz) begin
         per <= '0;
         start <= 1'b1;
         pps_out <= 1'b0;
      end else begin
         per <= idle ? '0 : (wrap ? (per == LAST ? '0 : per + 1'b1) : per);
         start <= idle || wrap;
         pps_out <= !idle && start && per == '0;
      end
   end
endmodule

// File: rtl/clock_ref_out.sv
// clock_ref_out: 10 MHz reference as ODDR rising/falling data halves from the 250 MHz clock.
// Defining CLOCK_REF_OUT_PPS_EN adds the PPS marker on pps_out.
module clock_ref_out
   import clock_ref_out_pkg::*;
#(
   parameter int DIV = DEF_DIV,
   parameter int PPS_DIV = DEF_PPS_DIV
) (
   input  logic clk_250mhz,
   input  logic rst_250mhz,
   input  logic enable,
   input  logic adj_valid,
   input  logic adj_dir,
   output logic adj_ready,
   output logic ref_d1,
   output logic ref_d2,
   output logic running,
   output logic pps_out
);
   localparam int CW = $clog2(DIV);
   localparam logic [CW:0] DIV_W = (CW+1)'(DIV);
   state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt, cnt_adv;
   logic [CW:0] step;
   logic active, acc, hold, wrap, d1_nxt, d2_nxt;
   if (DIV < 2 || PPS_DIV < 2) begin : g_bad_param
      $error("clock_ref_out: DIV and PPS_DIV must be >= 2");
   end
   assign adj_ready = state == RUN;
   assign running = state != IDLE;
   // wrap marks the last emitted cycle of a period; stopping is only allowed there
   always_comb begin
      active = state != IDLE;
      acc = adj_valid && adj_ready;
      hold = acc && adj_dir == ADJ_RETARD;
      step = {1'b0, cnt} + ((acc && adj_dir == ADJ_ADVANCE) ? (CW+1)'(2) : (CW+1)'(1));
      wrap = active && !hold && step >= DIV_W;
      cnt_adv = hold ? cnt : (step >= DIV_W ? CW'(step - DIV_W) : step[CW-1:0]);
      state_nxt = enable ? RUN : ((active && !wrap) ? STOP : IDLE);
      cnt_nxt = (active && (enable || !wrap)) ? cnt_adv : '0;
      d1_nxt = active && ({cnt, 1'b0} < DIV_W);
      d2_nxt = active && ({cnt, 1'b1} < DIV_W);
   end
   always_ff @(posedge clk_250mhz) begin
      if (rst_250mhz) begin
         state <= IDLE;
         cnt <= '0;
         ref_d1 <= 1'b0;
         ref_d2 <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         ref_d1 <= d1_nxt;
         ref_d2 <= d2_nxt;
      end
   end
`ifdef CLOCK_REF_OUT_PPS_EN
   clock_ref_out_pps #(.PPS_DIV(PPS_DIV)) u_pps (
      .clk_250mhz(clk_250mhz),
      .rst_250mhz(rst_250mhz),
      .wrap(wrap),
      .idle(state == IDLE),
      .pps_out(pps_out)
   );
`else
   assign pps_out = 1'b0;
`endif
endmodule
